seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Scan scheduler for the 6-digit multiplexed seven-segment display.
//  Accepts a 24-bit display word (6 nibbles) over a valid/ready load port and
//  time-shares the single digit bus d[3:0] across six digit enables seg_sel[5:0].
//  Double-buffers the display word so that updates land only at frame boundaries.
//  Inserts a blanking guard at the start of each digit slot to suppress ghosting.
// PARAMETERS
//  PRESCALE  1024  clocks per digit slot (>=2); full frame = 6*PRESCALE clocks
//  GUARD     16    blank clocks at start of each slot (0 <= GUARD < PRESCALE)
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  enable      in   1   1 = scan running; 0 = display dark, scan held at start of frame
//  lzb         in   1   1 = leading-zero blanking on
//  load_valid  in   1   load request
//  load_data   in   24  display word; nibble i drives digit i (digit 0 = LS nibble)
//  load_ready  out  1   1 = pending buffer empty, load accepted on valid&ready
//  d           out  4   nibble of the digit currently in its slot (raw, 0x0-0xF)
//  seg_sel     out  6   one-hot, active-high digit enable; all-zero = blank
//  frame_done  out  1   one-clock pulse in the last clock of slot 5
// BEHAVIOUR
//  - Reset (async): d=0, seg_sel=0, frame_done=0, load_ready=1,
//    shadow word=0, pending empty, slot counter=0, digit index=0.
//  - All outputs are registered; no combinational path from any input to any output.
//  - Counters: pcnt 0..PRESCALE-1, dig 0..5. pcnt wraps to 0 and dig increments.
//    dig wraps from 5 to 0. The first clock with enable=1 after reset is clock 0 of slot 0.
//  - Per slot:
//    - clocks 0..GUARD-1: seg_sel=0.
//    - clocks GUARD..PRESCALE-1: seg_sel=1<<dig, d=shadow[4*dig+:4].
//    - d is valid whenever seg_sel!=0; d holds its value during the guard.
//  - Scan order: digit 0 -> 5. Each digit is driven for exactly PRESCALE-GUARD clocks per frame.
//  - FSM states:
//    - OFF: enable=0. Go to GUARD on enable=1.
//    - GUARD: blank. Go to DRIVE when pcnt reaches GUARD-1; if GUARD=0, DRIVE is entered directly.
//    - DRIVE: digit enabled. Go to GUARD at the slot end.
//    - enable=0 from any state -> OFF on the next clock. In OFF: pcnt=0, dig=0, seg_sel=0.
//  - Load handshake:
//    - Accept when load_valid && load_ready: pending<=load_data and load_ready drops the next clock.
//    - load_ready stays 0 until the frame end. Loads offered while not ready are ignored
//      (the requester holds valid).
//  - Frame end (last clock of slot 5, frame_done=1):
//    - If pending is full: shadow<=pending, pending empties, load_ready=1 next clock.
//      The new word is displayed from slot 0 of the next frame.
//    - If pending is empty and a load is accepted on the same clock: the word goes to pending.
//      It is transferred at the following frame end, never in the same cycle.
//  - enable=0: loads are still accepted into pending. The pending-to-shadow transfer happens
//    only at a frame end, so no transfer occurs while enable=0.
//  - Leading-zero blanking (lzb=1):
//    - Digit k (5..1) is blanked (seg_sel=0 for its whole slot) when shadow nibbles 5..k are all zero.
//    - Digit 0 is never blanked.
//    - Slot timing is unchanged; the slot is only dark.
//  - lzb changes take effect at the next slot boundary.
//  - Reset mid-operation: all outputs go to their reset values immediately, without a clock.
//    Pending and shadow are cleared.
// TESTING  (bench parameters: PRESCALE=8, GUARD=2)
//  1. Assert reset asynchronously mid-slot 3 -> seg_sel=0, d=0, load_ready=1 before the next edge.
//     After release, frame_done first fires at clock 47.
//  2. Load 24'h123456 at frame 0:
//     - Frame 1: each slot is 2 clocks blank, then 6 clocks of (d, seg_sel):
//       6/000001, 5/000010, 4/000100, 3/001000, 2/010000, 1/100000.
//     - Frame period = 48 clocks.
//  3. Load 24'hAAAAAA, then immediately offer 24'hBBBBBB:
//     - load_ready=0 until frame_done.
//     - B is accepted the clock after the frame end and displayed one frame after A.
//     - d never mixes A and B nibbles within a frame.
//  4. lzb=1 with data 24'h000042 -> slots 2..5 fully dark; digit 0 shows 2, digit 1 shows 4.
//     With data 24'h000000 -> only seg_sel[0] with d=0. lzb=0 -> all six digits driven.
//  5. Drop enable during slot 3 DRIVE -> seg_sel=0 on the next clock.
//     Re-raise enable -> scan restarts at slot 0 with the full 2-clock guard.
//     A load during enable=0 is accepted but not displayed until the first frame end after re-enable.
//  6. Offer a load on the frame_done clock with pending empty -> accepted into pending.
//     load_ready=0 for the next full frame; the word is displayed two frames later.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment scan scheduler with a double-buffered display word,
// per-slot blanking guard and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int PRESCALE = 1024,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        lzb,
  input  logic        load_valid,
  input  logic [23:0] load_data,
  output logic        load_ready,
  output logic [3:0]  d,
  output logic [5:0]  seg_sel,
  output logic        frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] G_LEN  = PW'(GUARD);

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_DRIVE
  } st_e;

  st_e            st_q, st_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [2:0]     dig_q, dig_d;
  logic           lzb_q, lzb_d;

  logic [23:0]    shadow_q, shadow_d;
  logic [23:0]    pend_q, pend_d;
  logic           full_q, full_d;
  logic           rdy_q, rdy_d;
  logic [3:0]     d_q, d_d;
  logic [5:0]     sel_q, sel_d;
  logic           fd_q, fd_d;

  logic           acc;
  logic           xfer;
  logic [23:0]    sh_w;
  logic           blank;
  logic           drive;

  // State register: scan position of the cycle being displayed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_OFF;
      pcnt_q <= '0;
      dig_q  <= '0;
      lzb_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      pcnt_q <= pcnt_d;
      dig_q  <= dig_d;
      lzb_q  <= lzb_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    pcnt_d = pcnt_q;
    dig_d  = dig_q;
    lzb_d  = lzb_q;
    if (!enable) begin
      st_d   = S_OFF;
      pcnt_d = '0;
      dig_d  = '0;
    end else begin
      unique case (st_q)
        S_GUARD, S_DRIVE: begin
          if (pcnt_q == P_LAST) begin
            pcnt_d = '0;
            dig_d  = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        default: begin
          pcnt_d = '0;
          dig_d  = '0;
        end
      endcase
      st_d = (pcnt_d < G_LEN) ? S_GUARD : S_DRIVE;
      // lzb is only sampled when a new slot begins
      if (pcnt_d == '0) begin
        lzb_d = lzb;
      end
    end
  end

  always_comb begin
    acc      = load_valid && rdy_q;
    xfer     = fd_q && full_q;
    shadow_d = xfer ? pend_q : shadow_q;
    pend_d   = acc ? load_data : pend_q;
    full_d   = acc | (full_q & ~xfer);
    rdy_d    = ~full_d;

    sh_w  = shadow_d >> {dig_d, 2'b00};
    blank = lzb_d && (dig_d != 3'd0) && (sh_w == '0);
    drive = (st_d == S_DRIVE) && !blank;
    sel_d = drive ? (6'b1 << dig_d) : 6'b0;
    d_d   = drive ? sh_w[3:0] : d_q;
    fd_d  = (st_d != S_OFF) && (pcnt_d == P_LAST) && (dig_d == 3'd5);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      pend_q   <= '0;
      full_q   <= 1'b0;
      rdy_q    <= 1'b1;
      d_q      <= '0;
      sel_q    <= '0;
      fd_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      full_q   <= full_d;
      rdy_q    <= rdy_d;
      d_q      <= d_d;
      sel_q    <= sel_d;
      fd_q     <= fd_d;
    end
  end

  assign load_ready = rdy_q;
  assign d          = d_q;
  assign seg_sel    = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=8, GUARD=2:
// frame-by-frame expected digit/select/handshake patterns.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        lzb;
  logic        load_valid;
  logic [23:0] load_data;
  logic        load_ready;
  logic [3:0]  d;
  logic [5:0]  seg_sel;
  logic        frame_done;

  int n_chk = 0;
  int n_fail = 0;
  logic [23:0] req_q[$];

  seg_scan_ctrl #(.PRESCALE(8), .GUARD(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lzb        (lzb),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .d          (d),
    .seg_sel    (seg_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [23:0] w, input int s);
    logic [23:0] t;
    t = w >> (4 * s);
    return t[3:0];
  endfunction

  task automatic feed();
    if (!load_valid && req_q.size() > 0) begin
      load_data  = req_q.pop_front();
      load_valid = 1'b1;
    end
  endtask

  // Requester holds valid until an edge sees valid&ready
  task automatic tick();
    logic acc;
    feed();
    acc = load_valid && load_ready;
    @(posedge clk);
    #1;
    if (acc) load_valid = 1'b0;
    feed();
  endtask

  task automatic cyc(input int s, input int c, input logic [23:0] w,
                     input logic lz, input logic r0, input logic rn);
    logic [23:0] hi;
    logic        blk;
    logic [5:0]  es;
    tick();
    hi  = w >> (4 * s);
    blk = lz && (s != 0) && (hi == 24'h0);
    es  = (c < 2 || blk) ? 6'h0 : (6'h1 << s);
    chk("seg_sel", seg_sel, es);
    if (es != 6'h0) chk("d", d, nib(w, s));
    if (s > 0 && c < 2 && !lz) chk("d_hold", d, nib(w, s - 1));
    chk("frame_done", frame_done, (s == 5 && c == 7));
    chk("load_ready", load_ready, (s == 0 && c == 0) ? r0 : rn);
  endtask

  task automatic frame(input logic [23:0] w, input logic lz,
                       input logic r0, input logic rn);
    for (int i = 0; i < 48; i++) cyc(i / 8, i % 8, w, lz, r0, rn);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    lzb        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    tick();
    tick();
    chk("rst_d", d, 4'h0);
    chk("rst_sel", seg_sel, 6'h0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_rdy", load_ready, 1'b1);
    reset  = 1'b0;
    enable = 1'b1;

    req_q.push_back(24'h123456);
    frame(24'h000000, 1'b0, 1'b0, 1'b0);
    frame(24'h123456, 1'b0, 1'b1, 1'b1);

    req_q.push_back(24'hAAAAAA);
    req_q.push_back(24'hBBBBBB);
    frame(24'h123456, 1'b0, 1'b0, 1'b0);
    frame(24'hAAAAAA, 1'b0, 1'b1, 1'b0);

    req_q.push_back(24'h000042);
    frame(24'hBBBBBB, 1'b0, 1'b1, 1'b0);
    lzb = 1'b1;
    frame(24'h000042, 1'b1, 1'b1, 1'b1);
    req_q.push_back(24'h000000);
    frame(24'h000042, 1'b1, 1'b0, 1'b0);
    frame(24'h000000, 1'b1, 1'b1, 1'b1);
    lzb = 1'b0;
    req_q.push_back(24'h654321);
    frame(24'h000000, 1'b0, 1'b0, 1'b0);

    // Drop enable in slot 3 DRIVE, load while dark
    for (int i = 0; i < 27; i++)
      cyc(i / 8, i % 8, 24'h654321, 1'b0, 1'b1, 1'b1);
    enable = 1'b0;
    req_q.push_back(24'hFEDCBA);
    tick();
    chk("dis_sel", seg_sel, 6'h0);
    chk("dis_rdy", load_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dis_sel_hold", seg_sel, 6'h0);
      chk("dis_fd", frame_done, 1'b0);
    end
    enable = 1'b1;
    frame(24'h654321, 1'b0, 1'b0, 1'b0);
    frame(24'hFEDCBA, 1'b0, 1'b1, 1'b1);

    // Offer exactly on the frame_done clock
    req_q.push_back(24'h0F0F0F);
    frame(24'hFEDCBA, 1'b0, 1'b0, 1'b0);
    frame(24'h0F0F0F, 1'b0, 1'b1, 1'b1);

    // Async reset mid-slot 3 with a word pending
    req_q.push_back(24'h111111);
    for (int i = 0; i < 28; i++)
      cyc(i / 8, i % 8, 24'h0F0F0F, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sel", seg_sel, 6'h0);
    chk("arst_d", d, 4'h0);
    chk("arst_rdy", load_ready, 1'b1);
    chk("arst_fd", frame_done, 1'b0);
    @(posedge clk);
    #1;
    chk("arst_hold_sel", seg_sel, 6'h0);
    reset = 1'b0;
    frame(24'h000000, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
